// File: rtl/receptor_paridad_pkg.sv
// -----------------------------------------------------------------------------
// receptor_paridad_pkg
// Shared definitions for the serial parity receiver:
//   - estado_t : receiver state encoding (PARIDAD exists only with PARIDAD_EN)
//   - ANCHO_DATOS_DEF / CICLOS_POR_BIT_DEF : default parameter values
// Configuration macro: PARIDAD_EN (adds the parity bit to the frame).
// -----------------------------------------------------------------------------
package receptor_paridad_pkg;

  localparam int ANCHO_DATOS_DEF    = 8;
  localparam int CICLOS_POR_BIT_DEF = 16;

`ifdef PARIDAD_EN
  typedef enum logic [2:0] {
    REPOSO  = 3'd0,
    INICIO  = 3'd1,
    DATOS   = 3'd2,
    PARIDAD = 3'd3,
    PARADA  = 3'd4
  } estado_t;
`else
  typedef enum logic [2:0] {
    REPOSO  = 3'd0,
    INICIO  = 3'd1,
    DATOS   = 3'd2,
    PARADA  = 3'd4
  } estado_t;
`endif

endpackage

// File: rtl/sincronizador.sv
// -----------------------------------------------------------------------------
// sincronizador
// Two-flop synchronizer for an asynchronous, idle-high serial line.
// Both flops reset to 1 so a reset never looks like a start bit.
// Ports:
//   Reloj   in  clock
//   Reset   in  asynchronous active-high reset
//   d_i     in  asynchronous input
//   q_o     out synchronized output (two clock latency)
// -----------------------------------------------------------------------------
module sincronizador (
  input  logic Reloj,
  input  logic Reset,
  input  logic d_i,
  output logic q_o
);

  logic meta_q;
  logic sinc_q;

  always_ff @(posedge Reloj or posedge Reset) begin
    if (Reset) begin
      meta_q <= 1'b1;
      sinc_q <= 1'b1;
    end else begin
      meta_q <= d_i;
      sinc_q <= meta_q;
    end
  end

  assign q_o = sinc_q;

endmodule

// File: rtl/receptor_paridad_serie.sv
// -----------------------------------------------------------------------------
// receptor_paridad_serie
// Serial frame receiver: start bit, ANCHO_DATOS data bits LSB first,
// optional even-parity bit, one stop bit. Bits are sampled near their centre
// by counting CICLOS_POR_BIT clock cycles per bit after a half-bit delay.
// Configuration macro: PARIDAD_EN
//   defined   : frame = start + data + parity + stop, parity is checked
//   undefined : frame = start + data + stop, ErrorParidad tied to 0
// Ports:
//   Reloj        in  clock, rising edge
//   Reset        in  asynchronous active-high reset
//   Entrada      in  asynchronous serial line, idle high
//   Datos        out last received word (updated even on error)
//   Valido       out one-cycle pulse: frame received without error
//   ErrorParidad out one-cycle pulse: parity check failed
//   ErrorTrama   out one-cycle pulse: stop bit sampled low
//   Ocupado      out high whenever the receiver is not in REPOSO
// Outputs are registered; the result pulses appear on the cycle after the
// stop-bit sample. Internal state is visible on estado_q for checkers.
// -----------------------------------------------------------------------------
module receptor_paridad_serie
  import receptor_paridad_pkg::*;
#(
  parameter int ANCHO_DATOS    = ANCHO_DATOS_DEF,
  parameter int CICLOS_POR_BIT = CICLOS_POR_BIT_DEF
) (
  input  logic                   Reloj,
  input  logic                   Reset,
  input  logic                   Entrada,
  output logic [ANCHO_DATOS-1:0] Datos,
  output logic                   Valido,
  output logic                   ErrorParidad,
  output logic                   ErrorTrama,
  output logic                   Ocupado
);

  localparam int CW = $clog2(CICLOS_POR_BIT);
  localparam int BW = (ANCHO_DATOS > 1) ? $clog2(ANCHO_DATOS) : 1;

  localparam logic [CW-1:0] CNT_MEDIO  = CW'(CICLOS_POR_BIT / 2 - 1);
  localparam logic [CW-1:0] CNT_FIN    = CW'(CICLOS_POR_BIT - 1);
  localparam logic [BW-1:0] BIT_ULTIMO = BW'(ANCHO_DATOS - 1);

  logic rx;

  sincronizador u_sincronizador (
    .Reloj (Reloj),
    .Reset (Reset),
    .d_i   (Entrada),
    .q_o   (rx)
  );

  estado_t                estado_q;
  logic [CW-1:0]          cnt_q;
  logic [BW-1:0]          bits_q;
  logic [ANCHO_DATOS-1:0] desp_q;
  logic [ANCHO_DATOS-1:0] datos_q;
  logic                   valido_q;
  logic                   err_trama_q;
`ifdef PARIDAD_EN
  logic                   fallo_par_q;
  logic                   err_par_q;
`endif

  logic fin_bit;
  assign fin_bit = (cnt_q == CNT_FIN);

  always_ff @(posedge Reloj or posedge Reset) begin
    if (Reset) begin
      estado_q    <= REPOSO;
      cnt_q       <= '0;
      bits_q      <= '0;
      desp_q      <= '0;
      datos_q     <= '0;
      valido_q    <= 1'b0;
      err_trama_q <= 1'b0;
`ifdef PARIDAD_EN
      fallo_par_q <= 1'b0;
      err_par_q   <= 1'b0;
`endif
    end else begin
      // Result flags are pulses: cleared every cycle unless set below.
      valido_q    <= 1'b0;
      err_trama_q <= 1'b0;
`ifdef PARIDAD_EN
      err_par_q   <= 1'b0;
`endif
      case (estado_q)
        REPOSO: begin
          cnt_q  <= '0;
          bits_q <= '0;
          if (!rx) begin
            estado_q <= INICIO;
          end
        end

        INICIO: begin
          // Half-bit wait puts later samples near the bit centres.
          if (cnt_q == CNT_MEDIO) begin
            cnt_q    <= '0;
            estado_q <= rx ? REPOSO : DATOS;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end

        DATOS: begin
          if (fin_bit) begin
            cnt_q  <= '0;
            // LSB arrives first, so shift right and insert at the MSB.
            desp_q <= {rx, desp_q[ANCHO_DATOS-1:1]};
            bits_q <= bits_q + 1'b1;
            if (bits_q == BIT_ULTIMO) begin
`ifdef PARIDAD_EN
              estado_q <= PARIDAD;
`else
              estado_q <= PARADA;
`endif
            end
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end

`ifdef PARIDAD_EN
        PARIDAD: begin
          if (fin_bit) begin
            cnt_q       <= '0;
            // Even parity: data bits XOR parity bit must be 0.
            fallo_par_q <= (^desp_q) ^ rx;
            estado_q    <= PARADA;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
`endif

        PARADA: begin
          if (fin_bit) begin
            cnt_q       <= '0;
            estado_q    <= REPOSO;
            datos_q     <= desp_q;
            err_trama_q <= ~rx;
`ifdef PARIDAD_EN
            err_par_q   <= fallo_par_q;
            valido_q    <= rx & ~fallo_par_q;
`else
            valido_q    <= rx;
`endif
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end

        default: begin
          estado_q <= REPOSO;
          cnt_q    <= '0;
        end
      endcase
    end
  end

  assign Datos      = datos_q;
  assign Valido     = valido_q;
  assign ErrorTrama = err_trama_q;
  assign Ocupado    = (estado_q != REPOSO);
`ifdef PARIDAD_EN
  assign ErrorParidad = err_par_q;
`else
  assign ErrorParidad = 1'b0;
`endif

endmodule

// File: tb/tb_receptor_paridad_serie.sv
// -----------------------------------------------------------------------------
// tb_receptor_paridad_serie
// Directed frames for receptor_paridad_serie (ANCHO_DATOS=8, CICLOS_POR_BIT=16).
// Works with and without PARIDAD_EN: frame length, parity expectations and
// result latency follow the macro.
// Each frame pushes its expected word, flags and result cycle; a monitor on
// the falling edge pops one entry per result pulse.
// -----------------------------------------------------------------------------
module tb_receptor_paridad_serie;

  localparam int W   = 8;
  localparam int CPB = 16;
`ifdef PARIDAD_EN
  localparam bit PAR_ON = 1'b1;
`else
  localparam bit PAR_ON = 1'b0;
`endif
  localparam int NBITS = PAR_ON ? (W + 3) : (W + 2);
  // 2 sync flops + 1 detect cycle + half bit to centre of start bit,
  // then one full bit per remaining frame bit.
  localparam int LAT = 3 + CPB / 2 + CPB * (NBITS - 1);

  // ---------------- clock / reset ----------------
  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         entrada = 1'b1;
  logic [W-1:0] datos;
  logic         valido;
  logic         err_par;
  logic         err_trama;
  logic         ocupado;
  int           cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  receptor_paridad_serie #(
    .ANCHO_DATOS    (W),
    .CICLOS_POR_BIT (CPB)
  ) dut (
    .Reloj        (clk),
    .Reset        (rst),
    .Entrada      (entrada),
    .Datos        (datos),
    .Valido       (valido),
    .ErrorParidad (err_par),
    .ErrorTrama   (err_trama),
    .Ocupado      (ocupado)
  );

  // ---------------- scoreboard ----------------
  int           tests = 0;
  int           fails = 0;
  logic [W-1:0] exp_q[$];
  logic [2:0]   exp_flags_q[$];   // {valido, err_par, err_trama}
  int           exp_cyc_q[$];
  logic [W-1:0] datos_ref = '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // ---------------- monitor ----------------
  logic pulso_prev = 1'b0;

  always @(negedge clk) begin
    logic pulso;
    pulso = valido | err_par | err_trama;
    if (pulso) begin
      check("pulse_one_cycle", {31'd0, pulso_prev}, 32'd0);
      if (exp_q.size() == 0) begin
        check("unexpected_pulse", {29'd0, valido, err_par, err_trama}, 32'd0);
      end else begin
        logic [W-1:0] d;
        logic [2:0]   f;
        int           c;
        d = exp_q.pop_front();
        f = exp_flags_q.pop_front();
        c = exp_cyc_q.pop_front();
        check("flags", {29'd0, valido, err_par, err_trama}, {29'd0, f});
        check("datos", {24'd0, datos}, {24'd0, d});
        check("latency", cyc, c);
      end
    end
    pulso_prev = pulso;
  end

  // ---------------- driver tasks ----------------
  task automatic send_bit(input logic b);
    entrada = b;
    repeat (CPB) @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    entrada = 1'b1;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input logic [W-1:0] d, input logic par, input logic stop);
    logic e_par;
    e_par = PAR_ON & ((^d) ^ par);
    exp_q.push_back(d);
    exp_flags_q.push_back({~e_par & stop, e_par, ~stop});
    exp_cyc_q.push_back(cyc + LAT);
    datos_ref = d;
    send_bit(1'b0);
    check("ocupado_mid_frame", {31'd0, ocupado}, 32'd1);
    for (int i = 0; i < W; i++) send_bit(d[i]);
    if (PAR_ON) send_bit(par);
    send_bit(stop);
    idle(30);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    repeat (3) @(posedge clk);
    #1;
    check("reset_datos", {24'd0, datos}, 32'd0);
    check("reset_valido", {31'd0, valido}, 32'd0);
    check("reset_err_par", {31'd0, err_par}, 32'd0);
    check("reset_err_trama", {31'd0, err_trama}, 32'd0);
    check("reset_ocupado", {31'd0, ocupado}, 32'd0);
    rst = 1'b0;
    idle(5);

    send_frame(8'hA5, 1'b0, 1'b1);   // good frame
    send_frame(8'h01, 1'b0, 1'b1);   // parity error when parity enabled
    send_frame(8'h3C, 1'b0, 1'b0);   // framing error only
    send_frame(8'h07, 1'b0, 1'b0);   // parity + framing together
    send_frame(8'h00, 1'b0, 1'b1);
    send_frame(8'hFF, 1'b0, 1'b1);
    send_frame(8'h80, 1'b1, 1'b1);   // parity 1 correct for odd data
    send_frame(8'h81, 1'b0, 1'b1);

    // Short low glitch: receiver goes busy, rejects it, no pulse.
    entrada = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    entrada = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("glitch_ocupado_high", {31'd0, ocupado}, 32'd1);
    idle(20);
    check("glitch_ocupado_low", {31'd0, ocupado}, 32'd0);
    check("glitch_datos_held", {24'd0, datos}, {24'd0, datos_ref});

    // Reset in the middle of a frame of 0xFF after 3 data bits.
    send_bit(1'b0);
    for (int i = 0; i < 3; i++) send_bit(1'b1);
    rst = 1'b1;
    #1;
    check("midreset_ocupado", {31'd0, ocupado}, 32'd0);
    check("midreset_datos", {24'd0, datos}, 32'd0);
    datos_ref = '0;
    entrada = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    idle(20);
    check("after_reset_idle", {31'd0, ocupado}, 32'd0);
    send_frame(8'h5A, 1'b0, 1'b1);

    for (int i = 0; i < 2000 && exp_q.size() != 0; i++) @(posedge clk);
    check("pending_results", exp_q.size(), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/receptor_paridad_serie.md
RECEPTOR_PARIDAD_SERIE -- requirements
Module: receptor_paridad_serie

Interface
- REQ-001 SHALL have parameter ANCHO_DATOS, default 8, giving the number of data bits per frame.
- REQ-002 SHALL have parameter CICLOS_POR_BIT, default 16, giving the clock cycles per serial bit; legal values are even and at least 4.
- REQ-003 SHALL have port Reloj, input, 1 bit: the single clock; all state updates on its rising edge.
- REQ-004 SHALL have port Reset, input, 1 bit: asynchronous, active-high reset.
- REQ-005 SHALL have port Entrada, input, 1 bit: asynchronous serial line, idle high.
- REQ-006 SHALL have port Datos, output, ANCHO_DATOS bits: last received data word.
- REQ-007 SHALL have port Valido, output, 1 bit: one-cycle pulse when a frame completes with no error.
- REQ-008 SHALL have port ErrorParidad, output, 1 bit: one-cycle pulse when the parity check fails.
- REQ-009 SHALL have port ErrorTrama, output, 1 bit: one-cycle pulse when the stop bit samples low.
- REQ-010 SHALL have port Ocupado, output, 1 bit: high in every state except REPOSO.

Function
- REQ-011 SHALL pass Entrada through a two-flop synchronizer; all decisions use the synchronized line.
- REQ-012 SHALL implement states REPOSO, INICIO, DATOS, PARIDAD and PARADA.
- REQ-013 REPOSO -> INICIO SHALL occur on the first cycle the synchronized line is 0; the bit counter clears on entry.
- REQ-014 INICIO SHALL wait CICLOS_POR_BIT/2 cycles, then sample the line:
  - 0: go to DATOS.
  - 1: glitch; go to REPOSO with no output pulse.
- REQ-015 DATOS SHALL sample every CICLOS_POR_BIT cycles, taking ANCHO_DATOS bits LSB first, then go to PARIDAD.
- REQ-016 PARIDAD SHALL sample one bit and compute the XOR of all data bits and the parity bit (even parity); a result of 1 marks a parity error.
- REQ-017 PARADA SHALL sample one bit after CICLOS_POR_BIT cycles; a sample of 0 marks a framing error. The next state is REPOSO.
- REQ-018 On the cycle after the stop sample, the block SHALL:
  - load Datos;
  - pulse Valido only if there is no parity error and no framing error;
  - pulse ErrorParidad and/or ErrorTrama for each error present; both may pulse together.
- REQ-019 Datos SHALL hold its value between frames and SHALL be updated even on error.
- REQ-020 A new start bit SHALL NOT be detected until REPOSO is re-entered; a line low at the stop sample does not start a frame early.
- REQ-021 Valido, ErrorParidad and ErrorTrama SHALL never stay high for more than one cycle.

Reset
- REQ-022 Asserting Reset SHALL immediately force:
  - state REPOSO and all counters to 0;
  - synchronizer flops to 1;
  - Datos to 0;
  - Valido, ErrorParidad, ErrorTrama and Ocupado to 0.
- REQ-023 Reset asserted mid-frame SHALL discard the partial frame with no output pulse.

Configuration
- REQ-024 With macro PARIDAD_EN defined, the frame SHALL be start + ANCHO_DATOS data + parity + stop, and REQ-016 applies.
- REQ-025 Without PARIDAD_EN, the PARIDAD state SHALL be absent, DATOS SHALL go directly to PARADA, and ErrorParidad SHALL be tied to 0.

Structure
- REQ-026 Package receptor_paridad_pkg SHALL hold:
  - the state encoding typedef;
  - default constants for ANCHO_DATOS and CICLOS_POR_BIT.
- REQ-027 The two-flop synchronizer SHALL be sub-module sincronizador, reset to 1.

Verification (CICLOS_POR_BIT=16, ANCHO_DATOS=8, PARIDAD_EN defined unless stated)
- REQ-028 Frame 0xA5 with parity 0 and stop 1 -> one Valido pulse, Datos=0xA5, no error pulses.
- REQ-029 Frame 0x01 with parity 0 -> ErrorParidad pulse, Valido=0, Datos=0x01.
- REQ-030 Frame 0x3C with parity 0 and stop 0 -> ErrorTrama pulse only, Datos=0x3C.
- REQ-031 Entrada low for 4 cycles, then high -> Ocupado rises then returns to 0, no pulses, Datos unchanged.
- REQ-032 Reset asserted after 3 data bits of 0xFF, then frame 0x5A sent -> Ocupado=0 immediately after reset, then Valido with Datos=0x5A.
- REQ-033 PARIDAD_EN undefined, 10-bit frame 0x81 -> Valido pulse and Datos=0x81 at the stop bit plus 1 cycle; ErrorParidad stays 0.
